sha2_cmd_sequencer: RTL and testbench
=====================================

Name: sha2_cmd_sequencer

Overview:
- Sits between the UART byte receiver/transmitter and the SHA-256 compression core inside the top-level controller.
- Parses ASCII command lines from the host, loads 32-bit message words into the core, and starts/chains block compressions.
- Streams the 256-bit digest back as hex text.
- Drives status LEDs.

Parameters:
DONE_TIMEOUT, 1024, max cycles from core_start to core_done before a timeout reply
HEX_UPPER, 0, 1 = digest digits transmitted as 'A'-'F', 0 = 'a'-'f'

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous, active-low reset
rx_data  in  8  received byte
rx_valid  in  1  one-cycle pulse, rx_data valid
tx_data  out  8  byte to transmit
tx_valid  out  1  tx_data valid; held until accepted
tx_ready  in  1  transmitter accepts byte when tx_valid&tx_ready at clk edge
core_wr_en  out  1  one-cycle message-word write strobe
core_wr_addr  out  4  message word index 0..15
core_wr_data  out  32  message word
core_start  out  1  one-cycle start pulse
core_init  out  1  with core_start: 1 = load IV, 0 = chain from current digest
core_done  in  1  one-cycle pulse, compression finished
core_digest  in  256  H0..H7, H0 in [255:224]
led  out  8  status

Behaviour:
- Reset (rst_n low at clk edge): state IDLE. tx_valid, tx_data, core_wr_en, core_wr_addr, core_wr_data, core_start, core_init, led all 0. Line buffer and overflow flag cleared. Reset mid-transmission or mid-wait aborts immediately; a later core_done is ignored.
- States: IDLE, ARGS, EXEC, WAIT, TX.
- IDLE, on rx byte:
  - 'L'/'l' -> ARGS (mode LOAD). 'G'/'g', 'C'/'c', 'R'/'r' -> ARGS (mode GO/CONT/READ).
  - CR (0x0D) and LF (0x0A) ignored.
  - Any other byte -> error flag set, -> ARGS (mode ERR); the rest of the line is consumed.
- ARGS:
  - CR ignored. LF -> EXEC.
  - LOAD mode:
    - First hex digit = word index.
    - Subsequent digits shift left 4 into a 32-bit value (e.g. "L1123" -> index 1, 0x00000123).
    - Hex digits are case-insensitive.
    - Non-hex digit, or more than 8 value digits -> error.
  - G/C/R modes: any non-CR byte before LF -> error.
- EXEC (one cycle):
  - Error, or LOAD with no value digits -> reply "?\n".
  - LOAD: core_wr_en=1 for exactly one cycle with addr/data, then reply "K\n".
  - GO/CONT: core_start=1 for one cycle, core_init=1 for G and 0 for C, then -> WAIT.
  - READ: -> TX with 64 digest digits then LF.
- WAIT:
  - Counter starts at 0 on the cycle after core_start.
  - core_done -> reply "K\n".
  - Counter reaching DONE_TIMEOUT without core_done -> reply "T\n".
  - core_done on the same cycle as the timeout counts as done.
- TX:
  - Bytes are sent in order. tx_data is stable while tx_valid=1; the next byte is presented the cycle after acceptance.
  - Digest digits go MSB nibble first, from bit 255 down to bit 0.
  - core_digest is snapshotted in EXEC, so later changes do not corrupt output.
  - After the final LF is accepted -> IDLE, with tx_valid=0 on the next cycle.
  - With tx_ready held high, each byte occupies exactly 1 cycle.
- rx_valid in EXEC/WAIT/TX: byte dropped, sticky overflow flag set (cleared only by reset).
- Latency: LF received at edge N -> core_wr_en/core_start high in cycle N+1 -> first reply byte valid no earlier than N+2.
- led mapping:
  - led[2:0] = state code (IDLE=0, ARGS=1, EXEC=2, WAIT=3, TX=4).
  - led[3] = overflow flag.
  - led[7:4] = index of the last word written.

Test Plan:
- "L1123\n" -> one core_wr_en pulse with addr=1, data=0x00000123; tx bytes 'K', 0x0A; led[7:4]=1.
- Load words 0..15 of the padded "abc" block, then "G\n", then the core model pulses core_done 64 cycles later -> core_start with core_init=1, reply "K\n". Then "R\n" -> "ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad\n" (65 bytes).
- "C\n" -> core_start pulse with core_init=0; core never signals done -> after DONE_TIMEOUT cycles reply "T\n", state IDLE.
- Malformed lines "X\n", "L5\n", "L0123456789\n", "Gx\n" -> each reply "?\n"; core_wr_en and core_start never asserted.
- tx_ready toggled randomly during "R\n" -> tx_data stable while unaccepted; exactly 65 bytes in order. Bytes sent during TX are dropped and led[3]=1.
- rst_n low for one cycle mid-digest transmission -> next cycle all outputs 0; state IDLE; a following "L0ff\n" works normally.

Source files
------------

// File: rtl/sha2_cmd_sequencer.sv
// Host command sequencer for the SHA-256 core: parses ASCII lines, loads message words,
// starts/chains compressions and returns replies or the digest as hex text.
module sha2_cmd_sequencer #(
    parameter int unsigned DONE_TIMEOUT = 1024,
    parameter bit          HEX_UPPER    = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [7:0]   rx_data,
    input  logic         rx_valid,
    output logic [7:0]   tx_data,
    output logic         tx_valid,
    input  logic         tx_ready,
    output logic         core_wr_en,
    output logic [3:0]   core_wr_addr,
    output logic [31:0]  core_wr_data,
    output logic         core_start,
    output logic         core_init,
    input  logic         core_done,
    input  logic [255:0] core_digest,
    output logic [7:0]   led
);

    localparam int unsigned CntW = $clog2(DONE_TIMEOUT + 1);

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StArgs = 3'd1,
        StExec = 3'd2,
        StWait = 3'd3,
        StTx   = 3'd4
    } state_e;

    typedef enum logic [2:0] {ModeLoad, ModeGo, ModeCont, ModeRead, ModeErr} mode_e;
    typedef enum logic [1:0] {RepOk, RepErr, RepTime, RepDig} reply_e;

    state_e          state_q, state_d;
    mode_e           mode_q, mode_d;
    reply_e          reply_q, reply_d;
    logic            err_q, err_d;
    logic [3:0]      dig_cnt_q, dig_cnt_d;
    logic [3:0]      idx_q, idx_d;
    logic [31:0]     val_q, val_d;
    logic            ovf_q, ovf_d;
    logic [3:0]      last_idx_q, last_idx_d;
    logic [CntW-1:0] wait_cnt_q, wait_cnt_d;
    logic [6:0]      tx_cnt_q, tx_cnt_d;
    logic [255:0]    digest_q, digest_d;

    logic       rx_is_hex;
    logic [3:0] rx_nib;
    logic [3:0] tx_nib;
    logic [6:0] tx_last;
    logic [7:0] tx_char;
    logic [7:0] tx_byte;

    always_comb begin
        rx_is_hex = 1'b1;
        rx_nib    = 4'h0;
        if (rx_data >= 8'h30 && rx_data <= 8'h39) begin
            rx_nib = rx_data[3:0];
        end else if ((rx_data >= 8'h41 && rx_data <= 8'h46) ||
                     (rx_data >= 8'h61 && rx_data <= 8'h66)) begin
            rx_nib = rx_data[3:0] + 4'd9;
        end else begin
            rx_is_hex = 1'b0;
        end
    end

    // Digest digits come from the top nibble of a snapshot that shifts left per accepted digit.
    always_comb begin
        tx_nib  = digest_q[255:252];
        tx_last = (reply_q == RepDig) ? 7'd64 : 7'd1;
        case (reply_q)
            RepOk:   tx_char = 8'h4B;
            RepErr:  tx_char = 8'h3F;
            RepTime: tx_char = 8'h54;
            default: tx_char = (tx_nib < 4'd10) ? {4'h3, tx_nib} :
                               (HEX_UPPER ? 8'h41 : 8'h61) + {4'h0, tx_nib} - 8'd10;
        endcase
        tx_byte = (tx_cnt_q == tx_last) ? 8'h0A : tx_char;
    end

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        reply_d    = reply_q;
        err_d      = err_q;
        dig_cnt_d  = dig_cnt_q;
        idx_d      = idx_q;
        val_d      = val_q;
        ovf_d      = ovf_q;
        last_idx_d = last_idx_q;
        wait_cnt_d = wait_cnt_q;
        tx_cnt_d   = tx_cnt_q;
        digest_d   = digest_q;

        tx_valid     = 1'b0;
        tx_data      = 8'h00;
        core_wr_en   = 1'b0;
        core_wr_addr = 4'h0;
        core_wr_data = 32'h0;
        core_start   = 1'b0;
        core_init    = 1'b0;
        led          = {last_idx_q, ovf_q, state_q};

        if (rx_valid && (state_q == StExec || state_q == StWait || state_q == StTx)) begin
            ovf_d = 1'b1;
        end

        case (state_q)
            StIdle: begin
                if (rx_valid && rx_data != 8'h0D && rx_data != 8'h0A) begin
                    state_d   = StArgs;
                    err_d     = 1'b0;
                    dig_cnt_d = 4'd0;
                    idx_d     = 4'h0;
                    val_d     = 32'h0;
                    case (rx_data)
                        8'h4C, 8'h6C: mode_d = ModeLoad;
                        8'h47, 8'h67: mode_d = ModeGo;
                        8'h43, 8'h63: mode_d = ModeCont;
                        8'h52, 8'h72: mode_d = ModeRead;
                        default: begin
                            mode_d = ModeErr;
                            err_d  = 1'b1;
                        end
                    endcase
                end
            end
            StArgs: begin
                if (rx_valid && rx_data != 8'h0D) begin
                    if (rx_data == 8'h0A) begin
                        state_d = StExec;
                    end else if (mode_q == ModeLoad && rx_is_hex) begin
                        if (dig_cnt_q == 4'd0) begin
                            idx_d     = rx_nib;
                            dig_cnt_d = 4'd1;
                        end else if (dig_cnt_q == 4'd9) begin
                            err_d = 1'b1;
                        end else begin
                            val_d     = {val_q[27:0], rx_nib};
                            dig_cnt_d = dig_cnt_q + 4'd1;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StExec: begin
                state_d    = StTx;
                tx_cnt_d   = 7'd0;
                wait_cnt_d = '0;
                reply_d    = RepErr;
                // dig_cnt below 2 means the index or every value digit is missing.
                if (!err_q && !(mode_q == ModeLoad && dig_cnt_q < 4'd2)) begin
                    case (mode_q)
                        ModeLoad: begin
                            core_wr_en   = 1'b1;
                            core_wr_addr = idx_q;
                            core_wr_data = val_q;
                            last_idx_d   = idx_q;
                            reply_d      = RepOk;
                        end
                        ModeGo, ModeCont: begin
                            core_start = 1'b1;
                            core_init  = (mode_q == ModeGo);
                            state_d    = StWait;
                        end
                        ModeRead: begin
                            reply_d  = RepDig;
                            digest_d = core_digest;
                        end
                        default: reply_d = RepErr;
                    endcase
                end
            end
            StWait: begin
                if (core_done) begin
                    reply_d  = RepOk;
                    tx_cnt_d = 7'd0;
                    state_d  = StTx;
                end else if (wait_cnt_q == CntW'(DONE_TIMEOUT)) begin
                    reply_d  = RepTime;
                    tx_cnt_d = 7'd0;
                    state_d  = StTx;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            StTx: begin
                tx_valid = 1'b1;
                tx_data  = tx_byte;
                if (tx_ready) begin
                    if (tx_cnt_q == tx_last) begin
                        state_d = StIdle;
                    end else begin
                        tx_cnt_d = tx_cnt_q + 7'd1;
                        if (reply_q == RepDig) begin
                            digest_d = {digest_q[251:0], 4'h0};
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            mode_q     <= ModeLoad;
            reply_q    <= RepOk;
            err_q      <= 1'b0;
            dig_cnt_q  <= 4'd0;
            idx_q      <= 4'h0;
            val_q      <= 32'h0;
            ovf_q      <= 1'b0;
            last_idx_q <= 4'h0;
            wait_cnt_q <= '0;
            tx_cnt_q   <= 7'd0;
            digest_q   <= 256'h0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            reply_q    <= reply_d;
            err_q      <= err_d;
            dig_cnt_q  <= dig_cnt_d;
            idx_q      <= idx_d;
            val_q      <= val_d;
            ovf_q      <= ovf_d;
            last_idx_q <= last_idx_d;
            wait_cnt_q <= wait_cnt_d;
            tx_cnt_q   <= tx_cnt_d;
            digest_q   <= digest_d;
        end
    end

endmodule

// File: tb/tb_sha2_cmd_sequencer.sv
// Directed bench for sha2_cmd_sequencer: command parsing, core handshakes, replies, backpressure.
module tb_sha2_cmd_sequencer;

    localparam int unsigned TO = 100;
    localparam logic [255:0] DIG =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [7:0]   rx_data;
    logic         rx_valid;
    logic [7:0]   tx_data;
    logic         tx_valid;
    logic         tx_ready;
    logic         core_wr_en;
    logic [3:0]   core_wr_addr;
    logic [31:0]  core_wr_data;
    logic         core_start;
    logic         core_init;
    logic         core_done;
    logic [255:0] core_digest;
    logic [7:0]   led;

    int tests = 0;
    int fails = 0;

    sha2_cmd_sequencer #(
        .DONE_TIMEOUT(TO),
        .HEX_UPPER   (1'b0)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .core_wr_en  (core_wr_en),
        .core_wr_addr(core_wr_addr),
        .core_wr_data(core_wr_data),
        .core_start  (core_start),
        .core_init   (core_init),
        .core_done   (core_done),
        .core_digest (core_digest),
        .led         (led)
    );

    always #5 clk = ~clk;

    // Monitor: samples on the falling edge, records writes, starts and accepted bytes.
    int          cyc = 0;
    int          wr_cnt = 0;
    int          wr_cyc = 0;
    int          start_cnt = 0;
    int          start_cyc = 0;
    int          stab_err = 0;
    logic [3:0]  wr_addr_l = 4'h0;
    logic [31:0] wr_data_l = 32'h0;
    logic        init_l = 1'b0;
    logic [31:0] wr_mem [16];
    logic [7:0]  txq [$];
    int          txcyc [$];
    logic        held_v = 1'b0;
    logic [7:0]  held_b = 8'h00;

    always @(negedge clk) begin
        cyc++;
        if (core_wr_en) begin
            wr_cnt++;
            wr_cyc = cyc;
            wr_addr_l = core_wr_addr;
            wr_data_l = core_wr_data;
            wr_mem[core_wr_addr] = core_wr_data;
        end
        if (core_start) begin
            start_cnt++;
            start_cyc = cyc;
            init_l = core_init;
        end
        if (tx_valid) begin
            if (held_v && tx_data !== held_b) stab_err++;
            if (tx_ready) begin
                txq.push_back(tx_data);
                txcyc.push_back(cyc);
                held_v = 1'b0;
            end else begin
                held_v = 1'b1;
                held_b = tx_data;
            end
        end else begin
            held_v = 1'b0;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic send_line(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic wait_bytes(input int n, input int budget, output bit ok);
        int k = 0;
        while (txq.size() < n && k < budget) begin
            tick();
            k++;
        end
        ok = (txq.size() >= n);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b1;
        core_done = 1'b0; core_digest = 256'h0;
        repeat (3) tick();
        tests++;
        if ({tx_valid, tx_data, core_wr_en, core_wr_addr, core_wr_data, core_start, core_init,
             led} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got tx_valid=%b tx_data=%h wr_en=%b start=%b led=%h, expected all 0",
                     tx_valid, tx_data, core_wr_en, core_start, led);
        end
        rst_n = 1'b1;
        tick();
        tests++;
        if (led !== 8'h00) begin
            fails++;
            $display("FAIL reset_led_idle: got %h expected 00", led);
        end
    endtask

    task automatic test_load();
        int base = txq.size();
        int w0 = wr_cnt;
        bit ok;
        send_line("L1123\n");
        wait_bytes(base + 2, 50, ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL load_reply_timeout: got %0d bytes expected 2", txq.size() - base);
        end else begin
            tests++;
            if ({txq[base], txq[base+1]} !== {8'h4B, 8'h0A}) begin
                fails++;
                $display("FAIL load_reply: got %h %h expected 4b 0a", txq[base], txq[base+1]);
            end
            tests++;
            if (txcyc[base] <= wr_cyc) begin
                fails++;
                $display("FAIL load_latency: got reply cycle %0d expected after write cycle %0d",
                         txcyc[base], wr_cyc);
            end
        end
        tests++;
        if (wr_cnt - w0 !== 1 || wr_addr_l !== 4'h1 || wr_data_l !== 32'h123) begin
            fails++;
            $display("FAIL load_write: got n=%0d addr=%h data=%h expected n=1 addr=1 data=00000123",
                     wr_cnt - w0, wr_addr_l, wr_data_l);
        end
        repeat (2) tick();
        tests++;
        if (led !== 8'h10) begin
            fails++;
            $display("FAIL load_led: got %h expected 10", led);
        end
    endtask

    task automatic test_sha_abc();
        logic [31:0] blk [16];
        string dstr = "ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad";
        int   base, w0, s0, bad, k;
        bit   ok;
        for (int i = 0; i < 16; i++) blk[i] = 32'h0;
        blk[0]  = 32'h61626380;
        blk[15] = 32'h00000018;
        w0 = wr_cnt;
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            base = txq.size();
            send_line($sformatf("L%0h%0h\n", i, blk[i]));
            wait_bytes(base + 2, 50, ok);
            if (!ok || txq[base] !== 8'h4B) bad++;
        end
        tests++;
        if (bad != 0 || wr_cnt - w0 != 16) begin
            fails++;
            $display("FAIL abc_load_replies: got %0d bad replies, %0d writes expected 0 and 16",
                     bad, wr_cnt - w0);
        end
        bad = 0;
        for (int i = 0; i < 16; i++) if (wr_mem[i] !== blk[i]) bad++;
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL abc_block_words: got %0d wrong words expected 0", bad);
        end

        s0 = start_cnt;
        base = txq.size();
        send_line("G\n");
        k = 0;
        while (start_cnt == s0 && k < 20) begin tick(); k++; end
        tests++;
        if (start_cnt - s0 !== 1 || init_l !== 1'b1) begin
            fails++;
            $display("FAIL go_start: got starts=%0d init=%b expected 1 and 1", start_cnt - s0, init_l);
        end
        repeat (64) tick();
        core_digest = DIG;
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        wait_bytes(base + 2, 20, ok);
        tests++;
        if (!ok || {txq[base], txq[base+1]} !== {8'h4B, 8'h0A}) begin
            fails++;
            $display("FAIL go_reply: got ok=%b bytes %h %h expected 4b 0a",
                     ok, ok ? txq[base] : 8'h00, ok ? txq[base+1] : 8'h00);
        end

        base = txq.size();
        send_line("R\n");
        wait_bytes(base + 65, 200, ok);
        bad = 0;
        if (ok) begin
            for (int i = 0; i < 64; i++) if (txq[base+i] !== dstr[i]) bad++;
            if (txq[base+64] !== 8'h0A) bad++;
        end
        tests++;
        if (!ok || bad != 0) begin
            fails++;
            $display("FAIL read_digest: got ok=%b %0d wrong bytes expected 65 correct bytes", ok, bad);
        end
        repeat (2) tick();
    endtask

    task automatic test_timeout();
        int  base, s0, k, w0, d;
        bit  ok;
        s0 = start_cnt;
        w0 = wr_cnt;
        base = txq.size();
        send_line("C\n");
        k = 0;
        while (start_cnt == s0 && k < 20) begin tick(); k++; end
        tests++;
        if (start_cnt - s0 !== 1 || init_l !== 1'b0) begin
            fails++;
            $display("FAIL cont_start: got starts=%0d init=%b expected 1 and 0", start_cnt - s0, init_l);
        end
        wait_bytes(base + 2, TO + 50, ok);
        tests++;
        if (!ok || {txq[base], txq[base+1]} !== {8'h54, 8'h0A}) begin
            fails++;
            $display("FAIL timeout_reply: got ok=%b bytes %h %h expected 54 0a",
                     ok, ok ? txq[base] : 8'h00, ok ? txq[base+1] : 8'h00);
        end
        if (ok) begin
            d = txcyc[base] - start_cyc;
            tests++;
            if (d < TO + 1 || d > TO + 3) begin
                fails++;
                $display("FAIL timeout_delay: got %0d cycles expected %0d..%0d", d, TO + 1, TO + 3);
            end
        end
        repeat (2) tick();
        tests++;
        if (led[2:0] !== 3'd0 || wr_cnt != w0) begin
            fails++;
            $display("FAIL timeout_idle: got state=%0d writes=%0d expected 0 and 0",
                     led[2:0], wr_cnt - w0);
        end
    endtask

    task automatic test_malformed();
        string bad [4] = '{"X\n", "L5\n", "L0123456789\n", "Gx\n"};
        int    base, w0, s0;
        bit    ok;
        for (int i = 0; i < 4; i++) begin
            base = txq.size();
            w0 = wr_cnt;
            s0 = start_cnt;
            send_line(bad[i]);
            wait_bytes(base + 2, 50, ok);
            tests++;
            if (!ok || {txq[base], txq[base+1]} !== {8'h3F, 8'h0A}) begin
                fails++;
                $display("FAIL malformed_reply[%0d]: got ok=%b bytes %h %h expected 3f 0a", i,
                         ok, ok ? txq[base] : 8'h00, ok ? txq[base+1] : 8'h00);
            end
            tests++;
            if (wr_cnt != w0 || start_cnt != s0) begin
                fails++;
                $display("FAIL malformed_side_effect[%0d]: got writes=%0d starts=%0d expected 0 0",
                         i, wr_cnt - w0, start_cnt - s0);
            end
            repeat (2) tick();
        end
    endtask

    task automatic test_back_to_back_backpressure();
        string dstr = "ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad";
        int    base, e0, w0, bad, k;
        core_digest = DIG;
        base = txq.size();
        e0 = stab_err;
        w0 = wr_cnt;
        send_line("R\n");
        tick();
        core_digest = ~DIG;
        k = 0;
        while (txq.size() < base + 65 && k < 2000) begin
            tx_ready = 1'($urandom_range(0, 1));
            if (k == 5) begin
                rx_valid = 1'b1;
                rx_data  = 8'h4C;
            end else begin
                rx_valid = 1'b0;
                rx_data  = 8'h00;
            end
            tick();
            k++;
        end
        tx_ready = 1'b1;
        rx_valid = 1'b0;
        bad = 0;
        if (txq.size() >= base + 65) begin
            for (int i = 0; i < 64; i++) if (txq[base+i] !== dstr[i]) bad++;
            if (txq[base+64] !== 8'h0A) bad++;
        end else begin
            bad = 65;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL bp_digest: got %0d wrong/missing bytes expected 0", bad);
        end
        tests++;
        if (stab_err != e0) begin
            fails++;
            $display("FAIL bp_stable: got %0d changes while held expected 0", stab_err - e0);
        end
        repeat (3) tick();
        tests++;
        if (txq.size() != base + 65 || led[3] !== 1'b1 || led[2:0] !== 3'd0 || wr_cnt != w0) begin
            fails++;
            $display("FAIL bp_overflow: got bytes=%0d led=%h writes=%0d expected 65, led[3]=1 idle, 0",
                     txq.size() - base, led, wr_cnt - w0);
        end
    endtask

    task automatic test_reset_mid_tx();
        int base, n, w0;
        bit ok;
        core_digest = DIG;
        base = txq.size();
        send_line("R\n");
        wait_bytes(base + 10, 100, ok);
        rst_n = 1'b0;
        tick();
        tests++;
        if ({tx_valid, tx_data, core_wr_en, core_wr_addr, core_wr_data, core_start, core_init,
             led} !== '0) begin
            fails++;
            $display("FAIL midtx_reset: got tx_valid=%b tx_data=%h led=%h expected all 0",
                     tx_valid, tx_data, led);
        end
        rst_n = 1'b1;
        n = txq.size();
        repeat (5) tick();
        tests++;
        if (txq.size() != n || tx_valid !== 1'b0) begin
            fails++;
            $display("FAIL midtx_aborted: got %0d extra bytes tx_valid=%b expected 0 and 0",
                     txq.size() - n, tx_valid);
        end
        base = txq.size();
        w0 = wr_cnt;
        send_line("L0ff\n");
        wait_bytes(base + 2, 50, ok);
        tests++;
        if (!ok || {txq[base], txq[base+1]} !== {8'h4B, 8'h0A} || wr_cnt - w0 != 1 ||
            wr_addr_l !== 4'h0 || wr_data_l !== 32'hff) begin
            fails++;
            $display("FAIL after_reset_load: got ok=%b writes=%0d addr=%h data=%h expected K, 1, 0, ff",
                     ok, wr_cnt - w0, wr_addr_l, wr_data_l);
        end
        repeat (2) tick();
    endtask

    initial begin
        test_reset();
        test_load();
        test_sha_abc();
        test_timeout();
        test_malformed();
        test_back_to_back_backpressure();
        test_reset_mid_tx();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
